// File: rtl/usb_attach_ctrl.sv
// Attach/detach sequencing for the USB DFU pin wrapper: owns the host pull-up and core reset,
// and qualifies bus reset (SE0) and suspend (idle J) from the received line state.
module usb_attach_ctrl #(
    parameter int unsigned DISCONNECT_CYCLES = 480000,
    parameter int unsigned BUS_RESET_CYCLES  = 120,
    parameter int unsigned SUSPEND_CYCLES    = 144000
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       usb_p_rx,
    input  logic       usb_n_rx,
    input  logic       usb_tx_en,
    input  logic       detach_req,
    output logic       pin_pu,
    output logic       core_reset,
    output logic       bus_reset,
    output logic       suspended,
    output logic [1:0] state
);

    localparam int unsigned DisW  = (DISCONNECT_CYCLES > 1) ? $clog2(DISCONNECT_CYCLES) : 1;
    localparam int unsigned Se0W  = $clog2(BUS_RESET_CYCLES + 1);
    localparam int unsigned IdleW = $clog2(SUSPEND_CYCLES + 1);

    localparam logic [DisW-1:0]  DisLast  = DisW'(DISCONNECT_CYCLES - 1);
    localparam logic [Se0W-1:0]  Se0Last  = Se0W'(BUS_RESET_CYCLES - 1);
    localparam logic [Se0W-1:0]  Se0Max   = Se0W'(BUS_RESET_CYCLES);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(SUSPEND_CYCLES - 1);
    localparam logic [IdleW-1:0] IdleMax  = IdleW'(SUSPEND_CYCLES);

    typedef enum logic [1:0] {
        StDisc    = 2'd0,
        StActive  = 2'd1,
        StBusRst  = 2'd2,
        StSuspend = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       p_sync_q, n_sync_q;
    logic [DisW-1:0]  dis_cnt_q, dis_cnt_d;
    logic [Se0W-1:0]  se0_cnt_q, se0_cnt_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             pin_pu_q, pin_pu_d;
    logic             core_reset_q, core_reset_d;
    logic             bus_reset_q, bus_reset_d;
    logic             suspended_q, suspended_d;

    logic line_p, line_n;
    logic line_se0, line_j;
    logic se0_sample, idle_sample;
    logic se0_hit, idle_hit, disc_done;
    logic state_change;

    // Two-flop synchronizers on the receive pins
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            p_sync_q <= 2'b00;
            n_sync_q <= 2'b00;
        end else begin
            p_sync_q <= {p_sync_q[0], usb_p_rx};
            n_sync_q <= {n_sync_q[0], usb_n_rx};
        end
    end

    always_comb begin
        line_p      = p_sync_q[1];
        line_n      = n_sync_q[1];
        line_se0    = ~line_p & ~line_n;
        line_j      = line_p & ~line_n;
        se0_sample  = line_se0 & ~usb_tx_en;
        idle_sample = line_j & ~usb_tx_en;
        // The qualifying sample is the one that would bring the count to its limit
        se0_hit     = se0_sample && (se0_cnt_q == Se0Last);
        idle_hit    = idle_sample && (idle_cnt_q == IdleLast);
        disc_done   = (dis_cnt_q == DisLast);
    end

    // State register
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state_q <= StDisc;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; detach_req outranks every line-state event
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StDisc: begin
                if (!detach_req && disc_done) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (detach_req) begin
                    state_d = StDisc;
                end else if (se0_hit) begin
                    state_d = StBusRst;
                end else if (idle_hit) begin
                    state_d = StSuspend;
                end
            end
            StBusRst: begin
                if (detach_req) begin
                    state_d = StDisc;
                end else if (!line_se0) begin
                    state_d = StActive;
                end
            end
            StSuspend: begin
                if (detach_req) begin
                    state_d = StDisc;
                end else if (!line_j) begin
                    state_d = StActive;
                end
            end
            default: begin
                state_d = StDisc;
            end
        endcase
    end

    assign state_change = (state_d != state_q);

    // Counters: disconnect timer runs only in DISC, line counters clear on any state change
    always_comb begin
        dis_cnt_d = '0;
        if (state_q == StDisc && !detach_req && !disc_done) begin
            dis_cnt_d = dis_cnt_q + DisW'(1);
        end

        se0_cnt_d = '0;
        if (!state_change && se0_sample) begin
            se0_cnt_d = (se0_cnt_q == Se0Max) ? se0_cnt_q : se0_cnt_q + Se0W'(1);
        end

        idle_cnt_d = '0;
        if (!state_change && idle_sample) begin
            idle_cnt_d = (idle_cnt_q == IdleMax) ? idle_cnt_q : idle_cnt_q + IdleW'(1);
        end
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            dis_cnt_q  <= '0;
            se0_cnt_q  <= '0;
            idle_cnt_q <= '0;
        end else begin
            dis_cnt_q  <= dis_cnt_d;
            se0_cnt_q  <= se0_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Output decode from the next state so the registered outputs align with state_q
    always_comb begin
        pin_pu_d     = (state_d != StDisc);
        core_reset_d = (state_d == StDisc) || (state_d == StBusRst);
        bus_reset_d  = (state_d == StBusRst) && (state_q != StBusRst);
        suspended_d  = (state_d == StSuspend);
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            pin_pu_q     <= 1'b0;
            core_reset_q <= 1'b1;
            bus_reset_q  <= 1'b0;
            suspended_q  <= 1'b0;
        end else begin
            pin_pu_q     <= pin_pu_d;
            core_reset_q <= core_reset_d;
            bus_reset_q  <= bus_reset_d;
            suspended_q  <= suspended_d;
        end
    end

    assign pin_pu     = pin_pu_q;
    assign core_reset = core_reset_q;
    assign bus_reset  = bus_reset_q;
    assign suspended  = suspended_q;
    assign state      = state_q;

endmodule
